// File: rtl/usb_uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing the USB UART transmit stream between NUM_REQ byte sources.
// Optional stall release is enabled by defining USB_ARB_TIMEOUT_EN.
module usb_uart_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int GRANT_W        = 3,
  parameter int TIMEOUT_CYCLES = 4800
) (
  input  logic                 clk_48mhz,
  input  logic                 reset,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_in_data,
  output logic                 uart_in_valid,
  input  logic                 uart_in_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [NUM_REQ-1:0]   grant_nxt;
  logic [GRANT_W-1:0]   owner;
  logic [GRANT_W-1:0]   owner_nxt;
  logic [GRANT_W-1:0]   last_idx;
  logic [GRANT_W-1:0]   last_idx_nxt;
  logic [GRANT_W-1:0]   pick;
  logic                 found;
  logic [7:0]           own_data;
  logic                 own_valid;
  logic                 own_last;
  logic                 xfer;
  logic                 stall_expire;

  if (((1 << GRANT_W) < NUM_REQ) || (NUM_REQ < 2) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
    $error("usb_uart_tx_arbiter: illegal parameter combination");
  end

  // Scan starts just after the previous owner and wraps modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] &&
            ((int'(last_idx) + k == i) || (int'(last_idx) + k == i + NUM_REQ))) begin
          found = 1'b1;
          pick  = GRANT_W'(i);
        end
      end
    end
  end

  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == GRANT_W'(i)) begin
        own_data  = req_data[8*i +: 8];
        own_valid = req_valid[i];
        own_last  = req_last[i];
      end
    end
  end

  assign busy          = (state == GRANT);
  assign uart_in_valid = busy & own_valid;
  assign uart_in_data  = busy ? own_data : 8'h00;
  assign xfer          = uart_in_valid & uart_in_ready;
  assign req_ready     = xfer ? grant : '0;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    owner_nxt    = owner;
    last_idx_nxt = last_idx;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          owner_nxt = pick;
          for (int i = 0; i < NUM_REQ; i++) begin
            grant_nxt[i] = (pick == GRANT_W'(i));
          end
        end
      end
      GRANT: begin
        if ((xfer && own_last) || stall_expire) begin
          state_nxt    = IDLE;
          grant_nxt    = '0;
          last_idx_nxt = owner;
        end
      end
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      last_idx <= GRANT_W'(NUM_REQ - 1);
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      owner    <= owner_nxt;
      last_idx <= last_idx_nxt;
    end
  end

`ifdef USB_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_cnt;

  // Counter is held at zero outside GRANT, so each new grant starts a fresh window.
  assign stall_expire = busy && !xfer && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_48mhz) begin
    if (reset || !busy || xfer) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      timeout <= 1'b0;
    end else begin
      timeout <= stall_expire;
    end
  end
`else
  assign stall_expire = 1'b0;
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// Directed bench for usb_uart_tx_arbiter: message-level source model plus per-cycle output prediction.
// Define USB_ARB_TIMEOUT_EN to also exercise the stall-release path (TIMEOUT_CYCLES=8).
module tb_usb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int GW = 3;
  localparam int TO = 8;

  logic           clk_48mhz = 1'b0;
  logic           reset = 1'b1;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_in_data;
  logic           uart_in_valid;
  logic           uart_in_ready = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout;

  usb_uart_tx_arbiter #(
    .NUM_REQ(N),
    .GRANT_W(GW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_48mhz(clk_48mhz),
    .reset(reset),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_ready(req_ready),
    .uart_in_data(uart_in_data),
    .uart_in_valid(uart_in_valid),
    .uart_in_ready(uart_in_ready),
    .grant(grant),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int vectors = 0;
  int miscompares = 0;

  // Each source walks through msgs messages of len bytes; hold forces its valid low.
  int src_len[N];
  int src_pos[N];
  int src_msgs[N];
  int src_msgno[N];
  bit src_act[N];
  bit src_hold[N];
  bit rst_cmd = 1'b1;
  bit rdy_cmd = 1'b0;

  // Reference: owner index (-1 when idle), previous owner, stall length, pending timeout pulse.
  int m_owner = -1;
  int m_last = N - 1;
  int m_stall = 0;
  bit m_to = 1'b0;
  int xfer_count = 0;
  int grant_order[$];

  logic [N-1:0] s_grant;
  logic [N-1:0] s_ready;
  logic         s_valid;
  logic         s_busy;
  logic         s_to;
  logic [7:0]   s_data;

  function automatic bit srcValid(input int i);
    return src_act[i] && !src_hold[i];
  endfunction

  function automatic bit srcLast(input int i);
    return src_pos[i] == src_len[i] - 1;
  endfunction

  function automatic logic [7:0] srcByte(input int i);
    return 8'(i * 64 + 16 * (src_msgno[i] % 4) + src_pos[i]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus();
    reset         = rst_cmd;
    uart_in_ready = rdy_cmd;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = srcValid(i);
      req_last[i]        = srcLast(i);
      req_data[8*i +: 8] = srcByte(i);
    end
  endtask

  task automatic clearSrcs();
    for (int i = 0; i < N; i++) begin
      src_len[i]   = 0;
      src_pos[i]   = 0;
      src_msgs[i]  = 0;
      src_msgno[i] = 0;
      src_act[i]   = 1'b0;
      src_hold[i]  = 1'b0;
    end
  endtask

  task automatic setSrc(input int i, input int len, input int msgs);
    src_len[i]   = len;
    src_pos[i]   = 0;
    src_msgs[i]  = msgs;
    src_msgno[i] = 0;
    src_act[i]   = 1'b1;
    src_hold[i]  = 1'b0;
  endtask

  // One clock: drive after the edge, sample and predict at the falling edge.
  task automatic step();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic         ev;
    logic [7:0]   ed;
    bit           xfer;
    bit           was_last;
    bit           found;
    int           c;
    @(posedge clk_48mhz);
    #1;
    applyStimulus();
    @(negedge clk_48mhz);
    s_grant = grant;
    s_ready = req_ready;
    s_valid = uart_in_valid;
    s_busy  = busy;
    s_to    = timeout;
    s_data  = uart_in_data;
    eg = '0;
    er = '0;
    ev = 1'b0;
    ed = 8'h00;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ev          = srcValid(m_owner);
      ed          = srcByte(m_owner);
      if (ev && rdy_cmd) er[m_owner] = 1'b1;
    end
    checkOutput("grant", 32'(s_grant), 32'(eg));
    checkOutput("busy", 32'(s_busy), 32'(m_owner >= 0));
    checkOutput("uart_in_valid", 32'(s_valid), 32'(ev));
    checkOutput("uart_in_data", 32'(s_data), 32'(ed));
    checkOutput("req_ready", 32'(s_ready), 32'(er));
    checkOutput("timeout", 32'(s_to), 32'(m_to));

    xfer     = (m_owner >= 0) && ev && rdy_cmd;
    was_last = 1'b0;
    if (xfer) begin
      xfer_count++;
      was_last = srcLast(m_owner);
      src_pos[m_owner]++;
      if (was_last) begin
        src_pos[m_owner] = 0;
        src_msgno[m_owner]++;
        src_msgs[m_owner]--;
        if (src_msgs[m_owner] <= 0) src_act[m_owner] = 1'b0;
      end
    end
    if (rst_cmd) begin
      m_owner = -1;
      m_last  = N - 1;
      m_stall = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && srcValid(c)) begin
            found   = 1'b1;
            m_owner = c;
            m_stall = 0;
            grant_order.push_back(c);
          end
        end
      end else if (xfer) begin
        m_stall = 0;
        if (was_last) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end else begin
        m_stall++;
`ifdef USB_ARB_TIMEOUT_EN
        if (m_stall == TO) begin
          m_last  = m_owner;
          m_owner = -1;
          m_to    = 1'b1;
        end
`endif
      end
    end
  endtask

  task automatic applyReset();
    clearSrcs();
    rst_cmd = 1'b1;
    step();
    rst_cmd = 1'b0;
    xfer_count = 0;
    grant_order.delete();
  endtask

  initial begin
    clearSrcs();

    // Single 14-byte message from requester 0.
    applyReset();
    rdy_cmd = 1'b1;
    setSrc(0, 14, 1);
    step();
    checkOutput("t1_grant_c0", 32'(s_grant), 32'h0);
    step();
    checkOutput("t1_grant_c1", 32'(s_grant), 32'h1);
    checkOutput("t1_data_c1", 32'(s_data), 32'h00);
    repeat (13) step();
    checkOutput("t1_xfers", 32'(xfer_count), 32'd14);
    step();
    checkOutput("t1_grant_after", 32'(s_grant), 32'h0);
    checkOutput("t1_busy_after", 32'(s_busy), 32'h0);

    // All three requesting 2-byte messages continuously.
    applyReset();
    rdy_cmd = 1'b1;
    for (int i = 0; i < N; i++) setSrc(i, 2, 2);
    repeat (18) step();
    checkOutput("t2_xfers", 32'(xfer_count), 32'd12);
    checkOutput("t2_order_len", 32'(grant_order.size()), 32'd6);
    if (grant_order.size() >= 4) begin
      checkOutput("t2_order0", 32'(grant_order[0]), 32'd0);
      checkOutput("t2_order1", 32'(grant_order[1]), 32'd1);
      checkOutput("t2_order2", 32'(grant_order[2]), 32'd2);
      checkOutput("t2_order3", 32'(grant_order[3]), 32'd0);
    end

    // Owner 1 drops valid mid-message while requester 2 waits.
    applyReset();
    rdy_cmd = 1'b1;
    setSrc(1, 6, 1);
    setSrc(2, 3, 1);
    repeat (3) step();
    src_hold[1] = 1'b1;
    repeat (5) begin
      step();
      checkOutput("t3_valid_hold", 32'(s_valid), 32'h0);
      checkOutput("t3_grant_hold", 32'(s_grant), 32'h2);
      checkOutput("t3_ready_hold", 32'(s_ready), 32'h0);
    end
    src_hold[1] = 1'b0;
    step();
    checkOutput("t3_resume_data", 32'(s_data), 32'h42);
    checkOutput("t3_resume_ready", 32'(s_ready), 32'h2);
    repeat (9) step();
    checkOutput("t3_xfers", 32'(xfer_count), 32'd9);
    checkOutput("t3_order_len", 32'(grant_order.size()), 32'd2);
    if (grant_order.size() == 2) begin
      checkOutput("t3_order0", 32'(grant_order[0]), 32'd1);
      checkOutput("t3_order1", 32'(grant_order[1]), 32'd2);
    end

    // Core stalls for 10 cycles during a grant.
    applyReset();
    rdy_cmd = 1'b1;
    setSrc(0, 4, 1);
    setSrc(1, 2, 1);
    repeat (2) step();
    rdy_cmd = 1'b0;
    repeat (10) begin
      step();
      checkOutput("t4_data_stall", 32'(s_data), 32'h01);
      checkOutput("t4_ready_stall", 32'(s_ready), 32'h0);
      checkOutput("t4_grant_stall", 32'(s_grant), 32'h1);
    end
    rdy_cmd = 1'b1;
    repeat (8) step();
    checkOutput("t4_xfers", 32'(xfer_count), 32'd6);

    // Reset while byte 3 of a 6-byte message is on the bus.
    applyReset();
    rdy_cmd = 1'b1;
    setSrc(0, 6, 1);
    repeat (3) step();
    rst_cmd = 1'b1;
    step();
    checkOutput("t5_data_byte3", 32'(s_data), 32'h02);
    rst_cmd = 1'b0;
    clearSrcs();
    setSrc(0, 1, 1);
    setSrc(1, 1, 1);
    grant_order.delete();
    step();
    checkOutput("t5_grant_post", 32'(s_grant), 32'h0);
    checkOutput("t5_valid_post", 32'(s_valid), 32'h0);
    step();
    checkOutput("t5_first_winner", 32'(s_grant), 32'h1);
    repeat (4) step();
    checkOutput("t5_order_len", 32'(grant_order.size()), 32'd2);
    if (grant_order.size() == 2) begin
      checkOutput("t5_order0", 32'(grant_order[0]), 32'd0);
      checkOutput("t5_order1", 32'(grant_order[1]), 32'd1);
    end

`ifdef USB_ARB_TIMEOUT_EN
    // Owner stalls with valid low until the stall window expires.
    applyReset();
    rdy_cmd = 1'b1;
    setSrc(0, 4, 1);
    setSrc(1, 2, 1);
    repeat (2) step();
    src_hold[0] = 1'b1;
    repeat (8) begin
      step();
      checkOutput("t6_no_timeout", 32'(s_to), 32'h0);
      checkOutput("t6_grant_held", 32'(s_grant), 32'h1);
    end
    step();
    checkOutput("t6_timeout_pulse", 32'(s_to), 32'h1);
    checkOutput("t6_grant_released", 32'(s_grant), 32'h0);
    step();
    checkOutput("t6_next_owner", 32'(s_grant), 32'h2);
    checkOutput("t6_pulse_end", 32'(s_to), 32'h0);
    src_act[0] = 1'b0;
    repeat (3) step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
